ag_input_queue: RTL

- Receiving end of the decode-to-address-generation interface.
- Accepts the decode bundle (de_* fields) when decode offers a valid, loadable instruction.
- Holds up to DEPTH bundles in a small in-order queue and presents the oldest to the AG datapath with a precomputed effective address.
- Returns back-pressure (de_stall) to decode when full.

---
 rtl/ag_input_queue.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ag_input_queue.sv
// rtl/ag_input_queue.sv - decode-to-AG input queue with precomputed effective address
module ag_input_queue #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ag_vin,
  input  logic             ld_ag,
  input  logic             flush,
  input  logic             ag_ready,
  input  logic             de_re,
  input  logic             de_we,
  input  logic             de_rmsel,
  input  logic             ro_needed,
  input  logic             rm_needed,
  input  logic [1:0]       de_alusel,
  input  logic [2:0]       de_jmp,
  input  logic [7:0]       de_modrm,
  input  logic [15:0]      de_sreg,
  input  logic [15:0]      de_ptr,
  input  logic [31:0]      de_dval,
  input  logic [31:0]      de_sval,
  input  logic [31:0]      de_disp,
  input  logic [31:0]      de_flags,
  input  logic [31:0]      de_flag_ld,
  output logic             de_stall,
  output logic             ag_v,
  output logic             ag_re,
  output logic             ag_we,
  output logic             ag_rmsel,
  output logic             ag_ro_needed,
  output logic             ag_rm_needed,
  output logic [1:0]       ag_alusel,
  output logic [2:0]       ag_jmp,
  output logic [7:0]       ag_modrm,
  output logic [15:0]      ag_sreg,
  output logic [15:0]      ag_ptr,
  output logic [31:0]      ag_dval,
  output logic [31:0]      ag_sval,
  output logic [31:0]      ag_disp,
  output logic [31:0]      ag_flags,
  output logic [31:0]      ag_flag_ld,
  output logic [31:0]      ag_ea,
  output logic [PTR_W:0]   ag_count
);

  typedef struct packed {
    logic        re;
    logic        we;
    logic        rmsel;
    logic        ro_needed;
    logic        rm_needed;
    logic [1:0]  alusel;
    logic [2:0]  jmp;
    logic [7:0]  modrm;
    logic [15:0] sreg;
    logic [15:0] ptr;
    logic [31:0] dval;
    logic [31:0] sval;
    logic [31:0] disp;
    logic [31:0] flags;
    logic [31:0] flag_ld;
    logic [31:0] ea;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           rd_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;

  assign de_stall = (ag_count == (PTR_W+1)'(DEPTH));
  assign ag_v     = (ag_count != '0);
  assign push     = ag_vin & ld_ag & ~de_stall;
  assign pop      = ag_v & ag_ready;

  // Assemble the incoming bundle; EA is folded in here so the AG stage sees it ready-made.
  always_comb begin
    wr_entry           = '0;
    wr_entry.re        = de_re;
    wr_entry.we        = de_we;
    wr_entry.rmsel     = de_rmsel;
    wr_entry.ro_needed = ro_needed;
    wr_entry.rm_needed = rm_needed;
    wr_entry.alusel    = de_alusel;
    wr_entry.jmp       = de_jmp;
    wr_entry.modrm     = de_modrm;
    wr_entry.sreg      = de_sreg;
    wr_entry.ptr       = de_ptr;
    wr_entry.dval      = de_dval;
    wr_entry.sval      = de_sval;
    wr_entry.disp      = de_disp;
    wr_entry.flags     = de_flags;
    wr_entry.flag_ld   = de_flag_ld;
    wr_entry.ea        = de_disp + {16'h0, de_ptr};
  end

  // Pointer and occupancy bookkeeping; flush wins over any concurrent push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      ag_count <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      ag_count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      ag_count <= ag_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Payload storage is never cleared; emptiness is handled by output masking.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= wr_entry;
  end

  // Present the head entry, forced to zero while the queue is empty.
  always_comb begin
    rd_entry = '0;
    if (ag_v) rd_entry = mem[head];
  end

  assign ag_re        = rd_entry.re;
  assign ag_we        = rd_entry.we;
  assign ag_rmsel     = rd_entry.rmsel;
  assign ag_ro_needed = rd_entry.ro_needed;
  assign ag_rm_needed = rd_entry.rm_needed;
  assign ag_alusel    = rd_entry.alusel;
  assign ag_jmp       = rd_entry.jmp;
  assign ag_modrm     = rd_entry.modrm;
  assign ag_sreg      = rd_entry.sreg;
  assign ag_ptr       = rd_entry.ptr;
  assign ag_dval      = rd_entry.dval;
  assign ag_sval      = rd_entry.sval;
  assign ag_disp      = rd_entry.disp;
  assign ag_flags     = rd_entry.flags;
  assign ag_flag_ld   = rd_entry.flag_ld;
  assign ag_ea        = rd_entry.ea;

endmodule
